regfile_fwd: RTL and testbench

General-purpose register file for the OpenMIPS core with operand forwarding. It holds 32 × 32-bit architectural registers and takes one write port from the WB stage. It provides two read ports to the ID stage. Each read port resolves RAW hazards by forwarding in-flight results from EX (ex_*), EX/MEM (mem_*) and the same-cycle WB write, in that priority order. It consumes the wd/wreg/wdata triple that the EX/MEM pipeline register produces.

---
 rtl/regfile_fwd_pkg.sv | 16 +
 rtl/regfile_fwd_fwd_sel.sv | 50 +++++
 rtl/regfile_fwd.sv | 88 ++++++++
 tb/tb_regfile_fwd.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/regfile_fwd_pkg.sv
// Shared register-file constants for the OpenMIPS ID stage.
package regfile_fwd_pkg;

    localparam int REG_W     = 32;
    localparam int REGADDR_W = 5;
    localparam int REG_NUM   = 1 << REGADDR_W;

    localparam logic [REG_W-1:0]     ZERO_WORD    = '0;
    localparam logic [REGADDR_W-1:0] NOP_REG_ADDR = '0;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;
    localparam logic RST_ENABLE   = 1'b0;
    localparam logic RST_DISABLE  = 1'b1;

endpackage

// File: rtl/regfile_fwd_fwd_sel.sv
// One read port: priority select between zeroing, EX, MEM, WB bypass
// and the array word.
module fwd_sel
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REGADDR_W
) (
    input  logic              Rst_n,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0] rdata
);

    logic zero_sel;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // Compares run beside the array read; only the final mux is serial.
    assign zero_sel = (Rst_n == RST_ENABLE) || (re != READ_ENABLE)
                    || (raddr == '0);
    assign ex_hit   = ex_wreg && (ex_wd == raddr);
    assign mem_hit  = mem_wreg && (mem_wd == raddr);
    assign wb_hit   = (wb_we == WRITE_ENABLE) && (wb_waddr == raddr);

    always_comb begin
        rdata = arr_data;
        if (zero_sel) begin
            rdata = '0;
        end else if (ex_hit) begin
            rdata = ex_wdata;
        end else if (mem_hit) begin
            rdata = mem_wdata;
        end else if (wb_hit) begin
            rdata = wb_wdata;
        end
    end

endmodule

// File: rtl/regfile_fwd.sv
// 32x32 register file with one WB write port and two forwarding
// read ports for the ID stage.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REGADDR_W,
    parameter int NREG   = REG_NUM
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // $0 is cleared by reset and never written, so it stays zero.
    always_comb begin
        regs_d = regs_q;
        if (Rst_n == RST_ENABLE) begin
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = '0;
            end
        end else if ((we == WRITE_ENABLE) && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    fwd_sel #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_sel1 (
        .Rst_n    (Rst_n),
        .re       (re1),
        .raddr    (raddr1),
        .arr_data (regs_q[raddr1]),
        .ex_wreg  (ex_wreg),
        .ex_wd    (ex_wd),
        .ex_wdata (ex_wdata),
        .mem_wreg (mem_wreg),
        .mem_wd   (mem_wd),
        .mem_wdata(mem_wdata),
        .wb_we    (we),
        .wb_waddr (waddr),
        .wb_wdata (wdata),
        .rdata    (rdata1)
    );

    fwd_sel #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_sel2 (
        .Rst_n    (Rst_n),
        .re       (re2),
        .raddr    (raddr2),
        .arr_data (regs_q[raddr2]),
        .ex_wreg  (ex_wreg),
        .ex_wd    (ex_wd),
        .ex_wdata (ex_wdata),
        .mem_wreg (mem_wreg),
        .mem_wd   (mem_wd),
        .mem_wdata(mem_wdata),
        .wb_we    (we),
        .wb_waddr (waddr),
        .wb_wdata (wdata),
        .rdata    (rdata2)
    );

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed and random checks of regfile_fwd against a behavioural model.
module tb_regfile_fwd;

    logic        clk = 1'b0;
    logic        Rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic        ex_wreg, mem_wreg;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;
    logic [31:0] rdata1, rdata2;

    logic [31:0] model [32];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    regfile_fwd dut (
        .clk      (clk),
        .Rst_n    (Rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re1      (re1),
        .raddr1   (raddr1),
        .re2      (re2),
        .raddr2   (raddr2),
        .ex_wreg  (ex_wreg),
        .ex_wd    (ex_wd),
        .ex_wdata (ex_wdata),
        .mem_wreg (mem_wreg),
        .mem_wd   (mem_wd),
        .mem_wdata(mem_wdata),
        .rdata1   (rdata1),
        .rdata2   (rdata2)
    );

    // Expected operand: the youngest in-flight producer of the register wins.
    function automatic logic [31:0] expect_rd(input logic re,
                                              input logic [4:0] ra);
        if (!Rst_n || !re || ra == 5'd0) return 32'd0;
        if (ex_wreg && ex_wd == ra) return ex_wdata;
        if (mem_wreg && mem_wd == ra) return mem_wdata;
        if (we && waddr == ra) return wdata;
        return model[ra];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!Rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
        #1;
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0;
        re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
        ex_wreg = 0; ex_wd = 0; ex_wdata = 0;
        mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'hx;
        idle();

        // reset discards a concurrent write and forwarding
        Rst_n = 0; we = 1; waddr = 5; wdata = 32'hDEAD_BEEF;
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 5;
        ex_wreg = 1; ex_wd = 5; ex_wdata = 32'h1111_1111;
        #1;
        check("rst_rd1", rdata1, 32'h0);
        check("rst_rd2", rdata2, 32'h0);
        tick();
        tick();
        Rst_n = 1; idle(); re1 = 1; raddr1 = 5;
        #1;
        check("post_rst_r5", rdata1, 32'h0);

        // write then read
        we = 1; waddr = 3; wdata = 32'h1234_5678;
        tick();
        idle(); re1 = 1; raddr1 = 3;
        #1;
        check("wr_rd3", rdata1, 32'h1234_5678);
        re1 = 0;
        #1;
        check("re_off", rdata1, 32'h0);

        // $0 is never written or forwarded
        we = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
        ex_wreg = 1; ex_wd = 0; ex_wdata = 32'hFFFF_FFFF;
        mem_wreg = 1; mem_wd = 0; mem_wdata = 32'hFFFF_FFFF;
        re1 = 1; raddr1 = 0;
        #1;
        check("r0_same", rdata1, 32'h0);
        tick();
        idle(); re1 = 1; raddr1 = 0;
        #1;
        check("r0_after", rdata1, 32'h0);

        // priority EX > MEM > WB > array
        we = 1; waddr = 7; wdata = 32'h1;
        tick();
        wdata = 32'h2;
        mem_wreg = 1; mem_wd = 7; mem_wdata = 32'h3;
        ex_wreg = 1; ex_wd = 7; ex_wdata = 32'h4;
        re1 = 1; raddr1 = 7;
        #1;
        check("pri_ex", rdata1, 32'h4);
        ex_wreg = 0;
        #1;
        check("pri_mem", rdata1, 32'h3);
        mem_wreg = 0;
        #1;
        check("pri_wb", rdata1, 32'h2);
        we = 0;
        #1;
        check("pri_arr", rdata1, 32'h1);

        // both ports, same and different addresses
        idle();
        mem_wreg = 1; mem_wd = 9; mem_wdata = 32'hA5A5_A5A5;
        re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 9;
        #1;
        check("dual_rd1", rdata1, 32'hA5A5_A5A5);
        check("dual_rd2", rdata2, 32'hA5A5_A5A5);
        raddr2 = 10;
        #1;
        check("dual_r10", rdata2, 32'h0);
        check("dual_rd1_hold", rdata1, 32'hA5A5_A5A5);
        tick();

        // random traffic, addresses biased to collide
        for (int c = 0; c < 2000; c++) begin
            Rst_n     = ($urandom_range(0, 99) != 0);
            we        = $urandom_range(0, 1);
            waddr     = 5'($urandom_range(0, 7));
            wdata     = $urandom;
            re1       = ($urandom_range(0, 7) != 0);
            re2       = ($urandom_range(0, 7) != 0);
            raddr1    = 5'($urandom_range(0, 3) == 0 ?
                           $urandom_range(0, 31) : $urandom_range(0, 7));
            raddr2    = 5'($urandom_range(0, 7));
            ex_wreg   = ($urandom_range(0, 3) == 0);
            ex_wd     = 5'($urandom_range(0, 7));
            ex_wdata  = $urandom;
            mem_wreg  = ($urandom_range(0, 3) == 0);
            mem_wd    = 5'($urandom_range(0, 7));
            mem_wdata = $urandom;
            #1;
            check("rnd_rd1", rdata1, expect_rd(re1, raddr1));
            check("rnd_rd2", rdata2, expect_rd(re2, raddr2));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
